// File: rtl/seg7_mux_capture.sv
// Recovers hex digits from a multiplexed active-low 7-segment bus (anode/segment taps).
// Define SEG7_CAPTURE_HEX_EN to also decode the letters A-F.
module seg7_mux_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  anode,
  input  logic [6:0]  segment,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic [15:0] frame_value,
  output logic        frame_valid,
  output logic        anode_err,
  output logic        seg_err
);

  localparam logic [7:0]  STABLE_MAX  = 8'(STABLE_CYCLES);
  localparam logic [10:0] SAMPLE_IDLE = 11'h7ff;

  logic [10:0] sample_reg, sample_next;
  logic [7:0]  stable_cnt_reg, stable_cnt_next;
  logic        commit_stb;

  logic [3:0]  digit_sel;
  logic [2:0]  low_count;
  logic        anode_idle, anode_onehot;

  logic [5:0]  seg_info;
  logic        seg_known, seg_blank;
  logic [3:0]  seg_value;

  logic        commit_digit, commit_bad_anode, commit_bad_seg;
  logic [3:0]  digit_we, blank_set, seen_mark;
  logic        frame_done;

  logic [15:0] digits_reg, digits_next;
  logic [3:0]  blank_reg, blank_next;
  logic [3:0]  seen_reg, seen_next;
  logic [15:0] frame_value_reg;
  logic        frame_valid_reg, anode_err_reg, seg_err_reg;

  // Returns {known, blank, value}; unknown patterns return all zeros.
  function automatic logic [5:0] seg_decode(input logic [6:0] seg);
    logic [5:0] r;
    r = 6'b0;
    case (seg)
      7'b1000000: r = {2'b10, 4'h0};
      7'b1111001: r = {2'b10, 4'h1};
      7'b0100100: r = {2'b10, 4'h2};
      7'b0110000: r = {2'b10, 4'h3};
      7'b0011001: r = {2'b10, 4'h4};
      7'b0010010: r = {2'b10, 4'h5};
      7'b0000010: r = {2'b10, 4'h6};
      7'b1111000: r = {2'b10, 4'h7};
      7'b0000000: r = {2'b10, 4'h8};
      7'b0010000: r = {2'b10, 4'h9};
`ifdef SEG7_CAPTURE_HEX_EN
      7'b0001000: r = {2'b10, 4'hA};
      7'b0000011: r = {2'b10, 4'hB};
      7'b1000110: r = {2'b10, 4'hC};
      7'b0100001: r = {2'b10, 4'hD};
      7'b0000110: r = {2'b10, 4'hE};
      7'b0001110: r = {2'b10, 4'hF};
`endif
      7'b1111111: r = {2'b11, 4'h0};
      default:    r = 6'b0;
    endcase
    return r;
  endfunction

  // Commit fires only on the transition into saturation, so a dwell commits once.
  always_comb begin
    sample_next = {anode, segment};
    if (sample_next != sample_reg) begin
      stable_cnt_next = 8'd1;
    end else if (stable_cnt_reg >= STABLE_MAX) begin
      stable_cnt_next = STABLE_MAX;
    end else begin
      stable_cnt_next = stable_cnt_reg + 8'd1;
    end
    commit_stb = (stable_cnt_next == STABLE_MAX) && (stable_cnt_reg != STABLE_MAX);
  end

  always_comb begin
    digit_sel    = ~anode;
    low_count    = {2'b0, digit_sel[0]} + {2'b0, digit_sel[1]}
                 + {2'b0, digit_sel[2]} + {2'b0, digit_sel[3]};
    anode_idle   = (anode == 4'b1111);
    anode_onehot = (low_count == 3'd1);

    seg_info  = seg_decode(segment);
    seg_known = seg_info[5];
    seg_blank = seg_info[4];
    seg_value = seg_info[3:0];

    commit_digit     = commit_stb && !anode_idle && anode_onehot;
    commit_bad_anode = commit_stb && !anode_idle && !anode_onehot;
    commit_bad_seg   = commit_digit && !seg_known;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      assign digit_we[gi]  = commit_digit && seg_known && !seg_blank && digit_sel[gi];
      assign blank_set[gi] = commit_digit && seg_known && seg_blank && digit_sel[gi];
      assign seen_mark[gi] = digit_we[gi] || blank_set[gi];
      assign digits_next[4*gi +: 4] = digit_we[gi] ? seg_value : digits_reg[4*gi +: 4];
      assign blank_next[gi] = digit_we[gi]  ? 1'b0 :
                              blank_set[gi] ? 1'b1 : blank_reg[gi];
    end
  endgenerate

  // The frame snapshot includes the value being committed on this same edge.
  always_comb begin
    seen_next  = seen_reg | seen_mark;
    frame_done = (seen_mark != 4'b0) && (seen_next == 4'b1111);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sample_reg      <= SAMPLE_IDLE;
      stable_cnt_reg  <= 8'd0;
      digits_reg      <= 16'h0000;
      blank_reg       <= 4'b1111;
      seen_reg        <= 4'b0000;
      frame_value_reg <= 16'h0000;
      frame_valid_reg <= 1'b0;
      anode_err_reg   <= 1'b0;
      seg_err_reg     <= 1'b0;
    end else begin
      sample_reg      <= sample_next;
      stable_cnt_reg  <= stable_cnt_next;
      digits_reg      <= digits_next;
      blank_reg       <= blank_next;
      seen_reg        <= frame_done ? 4'b0000 : seen_next;
      if (frame_done) begin
        frame_value_reg <= digits_next;
      end
      frame_valid_reg <= frame_done;
      anode_err_reg   <= commit_bad_anode;
      seg_err_reg     <= commit_bad_seg;
    end
  end

  assign digits      = digits_reg;
  assign blank       = blank_reg;
  assign frame_value = frame_value_reg;
  assign frame_valid = frame_valid_reg;
  assign anode_err   = anode_err_reg;
  assign seg_err     = seg_err_reg;

endmodule
